// File: rtl/handshake_pkg.sv
// Shared types for the four-phase req/ack writer stage.
package handshake_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_REL  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/handshake_writer_if.sv
// Producer-side valid/ready bus plus the four-phase req/a/ack link to the reader.
interface handshake_writer_if #(
    parameter int DATA_W = handshake_pkg::DEFAULT_DATA_W
);

    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              req;
    logic [DATA_W-1:0] a;
    logic              ack;

    modport master (
        input  din, din_valid, ack,
        output din_ready, req, a
    );

    modport slave (
        output din, din_valid, ack,
        input  din_ready, req, a
    );

endinterface

// File: rtl/handshake_fifo.sv
// Small circular FIFO; full/empty derive from the occupancy counter, pointers wrap naturally.
module handshake_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [DATA_W-1:0]          head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/handshake_writer.sv
// Four-phase writer: buffers producer bytes and sends each one as a full req/ack
// transaction, holding a stable from load until the next load.
module handshake_writer
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    handshake_writer_if.master         bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [15:0]                sent
);

    wr_state_e         state_q, state_d;
    logic              ack_meta_q, ack_s_q;
    logic              req_q, req_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] head;
    logic [15:0]       sent_q, sent_d;
    logic              push, pop, full, empty;

    assign push = bus.din_valid && !full;

    handshake_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (bus.din),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= W_IDLE;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            req_q      <= 1'b0;
            a_q        <= '0;
            sent_q     <= '0;
        end else begin
            state_q    <= state_d;
            ack_meta_q <= bus.ack;
            ack_s_q    <= ack_meta_q;
            req_q      <= req_d;
            a_q        <= a_d;
            sent_q     <= sent_d;
        end
    end

    // A high ack_s in W_IDLE holds off the load, so no transaction starts against a stale ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE:  if (!empty && !ack_s_q) state_d = W_REQ;
            W_REQ:   if (ack_s_q)            state_d = W_REL;
            W_REL:   if (!ack_s_q)           state_d = W_IDLE;
            default:                         state_d = W_IDLE;
        endcase
    end

    always_comb begin
        pop    = (state_q == W_IDLE) && (state_d == W_REQ);
        req_d  = (state_d == W_REQ);
        a_d    = pop ? head : a_q;
        sent_d = ((state_q == W_REL) && (state_d == W_IDLE)) ? sent_q + 16'd1 : sent_q;
    end

    assign bus.din_ready = !full;
    assign bus.req       = req_q;
    assign bus.a         = a_q;
    assign sent          = sent_q;

endmodule

// File: tb/tb_handshake_writer.sv
// Directed bench for handshake_writer with a four-phase reader model and byte scoreboard.
module tb_handshake_writer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  count;
    logic [15:0] sent;

    int n_checks = 0;
    int n_fail   = 0;

    handshake_writer_if #(.DATA_W(DATA_W)) bus ();

    handshake_writer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .count (count),
        .sent  (sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reader model: acks after a delay, captures a at ack time, releases after a delay.
    bit          reader_en = 1'b0;
    bit          rd_rand   = 1'b0;
    int          rd_dly    = 0;
    logic [7:0]  exp_q [$];

    initial begin
        logic [7:0] exp_b;
        int d;
        bus.ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reader_en && reset) begin
                if (bus.req && !bus.ack) begin
                    d = rd_rand ? int'($urandom_range(0, 7)) : rd_dly;
                    repeat (d) @(negedge clk);
                    if (exp_q.size() > 0) exp_b = exp_q.pop_front();
                    else                  exp_b = 'x;
                    check("rx_data", 32'(bus.a), 32'(exp_b));
                    bus.ack = 1'b1;
                end else if (!bus.req && bus.ack) begin
                    d = rd_rand ? int'($urandom_range(0, 7)) : rd_dly;
                    repeat (d) @(negedge clk);
                    bus.ack = 1'b0;
                end
            end
        end
    end

    // a may only move when the previous sample saw req and ack both low.
    bit         mon_en = 1'b0;
    int         a_viol = 0;
    int         max_cnt = 0;
    logic [7:0] a_prev = '0;
    logic       req_prev = 1'b0;
    logic       ack_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_en && (bus.a !== a_prev) && (req_prev || ack_prev)) a_viol++;
        if (int'(count) > max_cnt) max_cnt = int'(count);
        a_prev   = bus.a;
        req_prev = bus.req;
        ack_prev = bus.ack;
    end

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        bus.din       = b;
        bus.din_valid = 1'b1;
        while (!bus.din_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.din_ready) begin
            check("push_timeout", 32'(bus.din_ready), 32'd1);
            bus.din_valid = 1'b0;
        end else begin
            exp_q.push_back(b);
            @(negedge clk);
        end
    endtask

    task automatic wait_sent(input logic [15:0] target, input int budget, input string tag);
        int n = 0;
        while (sent !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sent), 32'(target));
    endtask

    initial begin
        bus.din       = '0;
        bus.din_valid = 1'b0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req",   32'(bus.req), 32'd0);
        check("rst_a",     32'(bus.a),   32'd0);
        check("rst_count", 32'(count),   32'd0);
        check("rst_sent",  32'(sent),    32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_din_ready", 32'(bus.din_ready), 32'd1);
        mon_en = 1'b1;

        // Single byte, reader responds immediately.
        reader_en = 1'b1;
        rd_rand   = 1'b0;
        rd_dly    = 0;
        push_byte(8'hA5);
        bus.din_valid = 1'b0;
        check("t1_count_pushed", 32'(count),   32'd1);
        check("t1_req_not_yet",  32'(bus.req), 32'd0);
        @(negedge clk);
        check("t1_req_rise", 32'(bus.req), 32'd1);
        check("t1_a_load",   32'(bus.a),   32'hA5);
        check("t1_count_popped", 32'(count), 32'd0);
        wait_sent(16'd1, 50, "t1_sent");
        check("t1_a_hold",  32'(bus.a),   32'hA5);
        check("t1_req_low", 32'(bus.req), 32'd0);

        // Reader stalled: first byte goes out, four more fill the FIFO.
        reader_en = 1'b0;
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        bus.din_valid = 1'b0;
        check("t2_count_full", 32'(count),         32'd4);
        check("t2_din_ready",  32'(bus.din_ready), 32'd0);
        check("t2_req_held",   32'(bus.req),       32'd1);
        check("t2_a_first",    32'(bus.a),         32'h01);
        reader_en = 1'b1;
        rd_dly    = 1;
        push_byte(8'h06);
        bus.din_valid = 1'b0;
        wait_sent(16'd7, 400, "t2_sent");
        check("t2_all_received", 32'(exp_q.size()), 32'd0);

        // Ack held high before data: load waits for two edges of ack low.
        reader_en = 1'b0;
        bus.ack   = 1'b1;
        repeat (3) @(negedge clk);
        push_byte(8'h3C);
        bus.din_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_req_blocked", 32'(bus.req), 32'd0);
        check("t3_count_held",  32'(count),   32'd1);
        bus.ack = 1'b0;
        @(negedge clk);
        check("t3_req_edge1", 32'(bus.req), 32'd0);
        @(negedge clk);
        check("t3_req_edge2", 32'(bus.req), 32'd0);
        @(negedge clk);
        check("t3_req_edge3", 32'(bus.req), 32'd1);
        check("t3_a_load",    32'(bus.a),   32'h3C);
        reader_en = 1'b1;
        rd_dly    = 0;
        wait_sent(16'd8, 50, "t3_sent");

        // Random producer gaps and reader delays.
        rd_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.din_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            push_byte(8'($urandom));
        end
        bus.din_valid = 1'b0;
        wait_sent(16'd1008, 30000, "t4_sent");
        check("t4_all_received", 32'(exp_q.size()), 32'd0);
        check("t4_a_stable",     32'(a_viol),       32'd0);
        check("t4_count_bound",  32'(max_cnt <= DEPTH), 32'd1);

        // Asynchronous reset in the middle of W_REQ.
        rd_rand   = 1'b0;
        reader_en = 1'b0;
        mon_en    = 1'b0;
        push_byte(8'h77);
        bus.din_valid = 1'b0;
        @(negedge clk);
        check("t5_req_pre", 32'(bus.req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t5_req_async",   32'(bus.req),       32'd0);
        check("t5_a_async",     32'(bus.a),         32'd0);
        check("t5_count_async", 32'(count),         32'd0);
        check("t5_sent_async",  32'(sent),          32'd0);
        check("t5_din_ready",   32'(bus.din_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Counter wrap from 0xFFFF.
        force dut.sent_q = 16'hFFFF;
        @(negedge clk);
        release dut.sent_q;
        @(negedge clk);
        check("t6_sent_preload", 32'(sent), 32'hFFFF);
        reader_en = 1'b1;
        rd_dly    = 0;
        push_byte(8'h5A);
        bus.din_valid = 1'b0;
        wait_sent(16'd0, 60, "t6_sent_wrap");
        check("t6_all_received", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_writer.md
# handshake_writer

Upstream producer stage for the two-way (four-phase) req/ack link. Accepts bytes from a local valid/ready source into a small FIFO. Sends each byte over the `req`/`a`/`ack` channel to the downstream reader, one complete four-phase transaction per byte, holding `a` stable for the whole transaction. Sits directly in front of the reader stage and drives its `req` and `a` inputs.

## Interface
Parameters:
- `DATA_W`, 8, width of `din` and `a`
- `DEPTH`, 4, FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock for the whole block
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `din`  in  DATA_W  producer data
- `din_valid`  in  1  producer has data
- `din_ready`  out  1  FIFO can accept; equals !full
- `req`  out  1  four-phase request to reader (registered)
- `a`  out  DATA_W  data to reader (registered)
- `ack`  in  1  four-phase acknowledge from reader (asynchronous to the FSM; synchronized internally)
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy
- `sent`  out  16  completed transactions, wraps at 65535→0

## Operation
- Push when `din_valid && din_ready`. Pop only in the FSM load step. Push into an empty FIFO never bypasses to `a`.
- `ack` passes through a 2-flop synchronizer, giving `ack_s`. All FSM decisions use `ack_s` only.
- FSM states:
  - `W_IDLE`: `req`=0. If FIFO non-empty and `ack_s`=0: pop the head into the `a` register, set `req`←1, go to `W_REQ`. Otherwise stay.
  - `W_REQ`: `req`=1. If `ack_s`=1: set `req`←0, go to `W_REL`.
  - `W_REL`: `req`=0. If `ack_s`=0: increment `sent`, go to `W_IDLE`.
- `a` changes only on the `W_IDLE` load step. It is therefore stable from `req` rise until the next load, which always follows `ack` low.
- Full FIFO: `din_ready`=0, no push. A simultaneous pop frees one slot, visible to `din_ready` the next cycle.
- Push and pop in the same cycle: `count` is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty use `count`.
- A spurious `ack_s`=1 in `W_IDLE` blocks the load until it drops. No transaction is started against a high `ack`.
- Reset (async, active-low): `req`=0, `a`=0, `din_ready`=1 once released, `count`=0, `sent`=0, FIFO emptied, sync flops 0, state `W_IDLE`.
- Reset mid-transaction aborts it; the data in flight is lost. The system resets reader and writer together.

## Timing
- Byte accepted into empty FIFO at edge N → pop and `req` high after edge N+1 (`a` valid the same edge).
- `ack` rising, sampled at edge M → `ack_s` high after M+1 → `req` low after edge M+2.
- `ack` falling, sampled at edge K → `sent` increments and state is `W_IDLE` after K+2. The next load is at K+3 at the earliest.
- Writer-side overhead: 6 cycles of synchronizer and FSM latency per byte, plus the reader's response time.
- `din_ready` is a pure function of registered `count`, with no combinational path from `din_valid`.

## Structure
- Package `handshake_pkg`: state enum (`W_IDLE`, `W_REQ`, `W_REL`) and the default `DATA_W`.
- Sub-module `handshake_fifo` (parameters `DATA_W`, `DEPTH`; push/pop/full/empty/count/head).
- The top level holds the synchronizer, FSM, `a` register and `sent` counter.

## Test plan
- Reset with `din_valid`=0 → `req`=0, `a`=0, `count`=0, `din_ready`=1, `sent`=0. Pull `reset` low mid-`W_REQ` → `req` drops to 0 asynchronously.
- Single byte 0xA5 with the bench reader model acking 1 cycle after `req`, releasing 1 cycle after `req` low → `a`=0xA5 stable across the transaction, `sent`=1, `req` high exactly 2 edges after push.
- Push 0x01..0x06 back-to-back, DEPTH=4, reader stalled with `ack`=0 → `din_ready` low after the 4th stored byte. After release, the reader receives 0x01..0x06 in order and `sent`=6.
- Hold `ack`=1 before any data, then push 0x3C → no `req` until `ack` is low for 2 edges.
- Random `din_valid` and random reader delays of 0–7 cycles over 1000 bytes → scoreboard order matches, no `a` change while `req`=1 or `ack_s`=1, and `count` never exceeds 4.
- Preload `sent` to 0xFFFF via 65535 transfers (or force), then one more transfer → `sent`=0.
